// File: rtl/axi_sr_responder_pkg.sv
// ---------------------------------------------------------------------------
// axi_sr_responder_pkg
// Shared types and constants for the AXI subordinate responder:
//   - FSM state enum
//   - AXI response and burst encodings
//   - channel bundle structs (initiator->responder and responder->initiator)
// ---------------------------------------------------------------------------
package axi_sr_responder_pkg;

   localparam int AXI_ID_W   = 4;
   localparam int AXI_ADDR_W = 16;
   localparam int AXI_DATA_W = 8;
   localparam int MEM_WORD_W = 32;
   localparam int BEATS_MAX  = MEM_WORD_W / AXI_DATA_W;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR      = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      W_COLLECT,
      W_MEM,
      W_WAIT,
      B_RESP,
      R_MEM,
      R_WAIT,
      R_SEND
   } sr_state_t;

   typedef struct packed {
      logic                  awvalid;
      logic [AXI_ID_W-1:0]   awid;
      logic [AXI_ADDR_W-1:0] awaddr;
      logic [7:0]            awlen;
      logic [2:0]            awsize;
      logic [1:0]            awburst;
      logic                  wvalid;
      logic [AXI_DATA_W-1:0] wdata;
      logic                  wstrb;
      logic                  wlast;
      logic                  arvalid;
      logic [AXI_ID_W-1:0]   arid;
      logic [AXI_ADDR_W-1:0] araddr;
      logic [7:0]            arlen;
      logic [2:0]            arsize;
      logic [1:0]            arburst;
      logic                  bready;
      logic                  rready;
   } axi_mosi_t;

   typedef struct packed {
      logic                  awready;
      logic                  wready;
      logic                  arready;
      logic                  bvalid;
      logic [AXI_ID_W-1:0]   bid;
      logic [1:0]            bresp;
      logic                  rvalid;
      logic [AXI_ID_W-1:0]   rid;
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            rresp;
      logic                  rlast;
   } axi_miso_t;

endpackage

// File: rtl/axi_sr_responder.sv
// ---------------------------------------------------------------------------
// axi_sr_responder
// AXI subordinate at a memory endpoint. Collects up to BEATS_MAX byte beats
// into one memory write word, or splits one memory read word into byte beats.
// One transaction outstanding at a time; AW/AR contention is resolved
// round-robin (write favoured after reset).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   out_mosi_i        AW/W/AR valid+payload, BREADY, RREADY
//   out_miso_o        AWREADY, WREADY, ARREADY, B and R valid+payload
//   mem_wr_o          1 = write request, 0 = read request
//   mem_addr_o        latched AWADDR/ARADDR
//   mem_req_valid_o   memory request valid
//   mem_req_ready_i   memory accepts request
//   mem_wdata_o       assembled write word
//   mem_resp_valid_i  one-cycle completion pulse
//   mem_rdata_i       read word, valid with mem_resp_valid_i
//
// Build option: AXI_SR_RESP_CHECK_EN enables burst-length checking on writes
// (mismatched WLAST or a 5th beat -> SLVERR, no memory access) and ARSIZE
// checking on reads (nonzero size -> zero data with SLVERR, no memory access).
// ---------------------------------------------------------------------------
module axi_sr_responder
   import axi_sr_responder_pkg::*;
#(
   parameter int ID_W_WIDTH     = axi_sr_responder_pkg::AXI_ID_W,
   parameter int ID_R_WIDTH     = axi_sr_responder_pkg::AXI_ID_W,
   parameter int ADDR_WIDTH     = axi_sr_responder_pkg::AXI_ADDR_W,
   parameter int DATA_WIDTH     = axi_sr_responder_pkg::AXI_DATA_W,
   parameter int MEM_DATA_WIDTH = axi_sr_responder_pkg::MEM_WORD_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  axi_mosi_t                 out_mosi_i,
   output axi_miso_t                 out_miso_o,
   output logic                      mem_wr_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic                      mem_req_valid_o,
   input  logic                      mem_req_ready_i,
   output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                      mem_resp_valid_i,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int BEAT_W = $clog2(BEATS_MAX);

   sr_state_t                 state;
   logic                      rr_q;       // 1 = read favoured on next contention
   logic [BEAT_W-1:0]         beat_q;
   logic [BEAT_W-1:0]         len_q;
   logic [ID_W_WIDTH-1:0]     aw_id_q;
   logic [ID_R_WIDTH-1:0]     ar_id_q;
   logic [MEM_DATA_WIDTH-1:0] rword_q;
   logic                      err_q;      // response for the current burst is SLVERR
`ifdef AXI_SR_RESP_CHECK_EN
   logic [BEAT_W:0]           wcnt_q;     // non-wrapping W beat count, catches a 5th beat
   logic                      w_bad;
`endif

   logic grant_w;
   logic grant_r;
   logic unused_ok;

   // Round-robin only matters when both address channels are valid together.
   assign grant_w = (state == IDLE) && out_mosi_i.awvalid && (!out_mosi_i.arvalid || !rr_q);
   assign grant_r = (state == IDLE) && out_mosi_i.arvalid && (!out_mosi_i.awvalid ||  rr_q);

`ifdef AXI_SR_RESP_CHECK_EN
   assign w_bad = (wcnt_q != {1'b0, len_q});
`endif

   assign mem_req_valid_o = (state == W_MEM) || (state == R_MEM);
   assign mem_wr_o        = (state == W_MEM);

   always_comb begin
      out_miso_o         = '0;
      out_miso_o.awready = grant_w;
      out_miso_o.arready = grant_r;
      out_miso_o.wready  = (state == W_COLLECT);
      out_miso_o.bvalid  = (state == B_RESP);
      out_miso_o.bid     = aw_id_q;
      out_miso_o.bresp   = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      out_miso_o.rvalid  = (state == R_SEND);
      out_miso_o.rid     = ar_id_q;
      out_miso_o.rdata   = rword_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
      out_miso_o.rresp   = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      out_miso_o.rlast   = (beat_q == len_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_q        <= 1'b0;
         beat_q      <= '0;
         len_q       <= '0;
         aw_id_q     <= '0;
         ar_id_q     <= '0;
         rword_q     <= '0;
         err_q       <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
`ifdef AXI_SR_RESP_CHECK_EN
         wcnt_q      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_w) begin
                  aw_id_q     <= out_mosi_i.awid;
                  mem_addr_o  <= out_mosi_i.awaddr;
                  len_q       <= out_mosi_i.awlen[BEAT_W-1:0];
                  mem_wdata_o <= '0;
                  beat_q      <= '0;
                  err_q       <= 1'b0;
                  rr_q        <= ~rr_q;
`ifdef AXI_SR_RESP_CHECK_EN
                  wcnt_q      <= '0;
`endif
                  state       <= W_COLLECT;
               end else if (grant_r) begin
                  ar_id_q    <= out_mosi_i.arid;
                  mem_addr_o <= out_mosi_i.araddr;
                  len_q      <= out_mosi_i.arlen[BEAT_W-1:0];
                  beat_q     <= '0;
                  err_q      <= 1'b0;
                  rr_q       <= ~rr_q;
                  state      <= R_MEM;
`ifdef AXI_SR_RESP_CHECK_EN
                  // Unsupported size: answer with zero data, skip memory.
                  if (out_mosi_i.arsize != 3'd0) begin
                     err_q   <= 1'b1;
                     rword_q <= '0;
                     state   <= R_SEND;
                  end
`endif
               end
            end

            W_COLLECT: begin
               if (out_mosi_i.wvalid) begin
                  if (out_mosi_i.wstrb)
                     mem_wdata_o[beat_q*DATA_WIDTH +: DATA_WIDTH] <= out_mosi_i.wdata;
                  beat_q <= beat_q + 1'b1;
`ifdef AXI_SR_RESP_CHECK_EN
                  wcnt_q <= wcnt_q + 1'b1;
                  if (out_mosi_i.wlast || (wcnt_q == BEATS_MAX[BEAT_W:0])) begin
                     if (w_bad) begin
                        err_q <= 1'b1;
                        state <= B_RESP;
                     end else begin
                        state <= W_MEM;
                     end
                  end
`else
                  if (out_mosi_i.wlast)
                     state <= W_MEM;
`endif
               end
            end

            W_MEM: begin
               if (mem_req_ready_i)
                  state <= mem_resp_valid_i ? B_RESP : W_WAIT;
            end

            W_WAIT: begin
               if (mem_resp_valid_i)
                  state <= B_RESP;
            end

            B_RESP: begin
               if (out_mosi_i.bready)
                  state <= IDLE;
            end

            R_MEM: begin
               if (mem_req_ready_i) begin
                  if (mem_resp_valid_i) begin
                     rword_q <= mem_rdata_i;
                     beat_q  <= '0;
                     state   <= R_SEND;
                  end else begin
                     state   <= R_WAIT;
                  end
               end
            end

            R_WAIT: begin
               if (mem_resp_valid_i) begin
                  rword_q <= mem_rdata_i;
                  beat_q  <= '0;
                  state   <= R_SEND;
               end
            end

            R_SEND: begin
               if (out_mosi_i.rready) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == len_q)
                     state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Payload bits this responder ignores (size/burst type, upper length bits).
   assign unused_ok = ^{out_mosi_i.awlen[7:BEAT_W], out_mosi_i.arlen[7:BEAT_W],
                        out_mosi_i.awsize, out_mosi_i.arsize,
                        out_mosi_i.awburst, out_mosi_i.arburst, BURST_INCR};

endmodule

// File: tb/tb_axi_sr_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_sr_responder
// Directed, table-driven bench for axi_sr_responder. Inputs are driven on the
// falling clock edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_axi_sr_responder;
   import axi_sr_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   axi_mosi_t   mosi;
   axi_miso_t   miso;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   axi_sr_responder dut (
      .clk              (clk),
      .rst              (rst),
      .out_mosi_i       (mosi),
      .out_miso_o       (miso),
      .mem_wr_o         (mem_wr),
      .mem_addr_o       (mem_addr),
      .mem_req_valid_o  (mem_req_valid),
      .mem_req_ready_i  (mem_req_ready),
      .mem_wdata_o      (mem_wdata),
      .mem_resp_valid_i (mem_resp_valid),
      .mem_rdata_i      (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      logic [3:0]  id;
      logic [15:0] addr;
      logic [1:0]  len;
      int          nbeats;
      logic [39:0] data;     // write: beat bytes, LSB first; read: memory word
      logic [4:0]  strb;     // per-beat WSTRB[0]
      int          delay;    // cycles from request accept to response (0 = same cycle)
      int          bstall;   // cycles BREADY held low
      logic [7:0]  rpat;     // RREADY pattern per cycle, LSB first
      logic [31:0] exp_word; // write: expected mem word; read: expected beat bytes
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [1:0] len,
                           input int nbeats, input logic [39:0] data, input logic [4:0] strb,
                           input int delay, input int bstall, input logic [31:0] exp_word,
                           input logic [1:0] exp_bresp, input bit exp_mem);
      mosi.awvalid = 1'b1; mosi.awid = id; mosi.awaddr = addr; mosi.awlen = {6'd0, len};
      #1 chk("awready", miso.awready, 1);
      step();
      mosi.awvalid = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         mosi.wvalid = 1'b1; mosi.wdata = data[b*8 +: 8]; mosi.wstrb = strb[b];
         mosi.wlast  = (b == nbeats - 1);
         #1 chk("wready", miso.wready, 1);
         chk("no_req_collect", mem_req_valid, 0);
         step();
      end
      mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
      #1;
      if (exp_mem) begin
         chk("wr_req_valid", mem_req_valid, 1);
         chk("wr_req_wr", mem_wr, 1);
         chk("wr_addr", mem_addr, addr);
         chk("wr_wdata", mem_wdata, exp_word);
         step();
         chk("wr_req_hold", mem_req_valid, 1);
         chk("wr_wdata_hold", mem_wdata, exp_word);
         mem_req_ready = 1'b1; mem_resp_valid = (delay == 0);
         step();
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         for (int k = 0; k < delay; k++) begin
            #1 chk("b_early", miso.bvalid, 0);
            if (k == delay - 1) mem_resp_valid = 1'b1;
            step();
            mem_resp_valid = 1'b0;
         end
         #1;
      end
      chk("no_req_in_b", mem_req_valid, 0);
      chk("bvalid", miso.bvalid, 1);
      chk("bid", miso.bid, id);
      chk("bresp", miso.bresp, exp_bresp);
      for (int k = 0; k < bstall; k++) begin
         step();
         #1 chk("bvalid_hold", miso.bvalid, 1);
         chk("bid_hold", miso.bid, id);
      end
      mosi.bready = 1'b1;
      step();
      mosi.bready = 1'b0;
      #1 chk("bvalid_done", miso.bvalid, 0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [1:0] len,
                          input logic [2:0] size, input logic [31:0] word, input int delay,
                          input logic [7:0] rpat, input logic [31:0] exp_word,
                          input logic [1:0] exp_rresp, input bit exp_mem);
      int beat;
      int cyc;
      mosi.arvalid = 1'b1; mosi.arid = id; mosi.araddr = addr; mosi.arlen = {6'd0, len};
      mosi.arsize = size;
      #1 chk("arready", miso.arready, 1);
      step();
      mosi.arvalid = 1'b0; mosi.arsize = 3'd0;
      #1;
      if (exp_mem) begin
         chk("rd_req_valid", mem_req_valid, 1);
         chk("rd_req_wr", mem_wr, 0);
         chk("rd_addr", mem_addr, addr);
         step();
         chk("rd_req_hold", mem_req_valid, 1);
         mem_req_ready = 1'b1;
         if (delay == 0) begin mem_resp_valid = 1'b1; mem_rdata = word; end
         step();
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
         for (int k = 0; k < delay; k++) begin
            #1 chk("r_early", miso.rvalid, 0);
            if (k == delay - 1) begin mem_resp_valid = 1'b1; mem_rdata = word; end
            step();
            mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
         end
      end else begin
         chk("rd_no_req", mem_req_valid, 0);
      end
      beat = 0;
      cyc  = 0;
      while (beat <= int'(len) && cyc < 40) begin
         mosi.rready = rpat[cyc % 8];
         #1 chk("rvalid", miso.rvalid, 1);
         chk("rdata", miso.rdata, exp_word[beat*8 +: 8]);
         chk("rid", miso.rid, id);
         chk("rresp", miso.rresp, exp_rresp);
         chk("rlast", miso.rlast, (beat == int'(len)));
         step();
         if (mosi.rready) beat++;
         cyc++;
      end
      mosi.rready = 1'b0;
      chk("r_beats_done", (cyc < 40), 1);
      #1 chk("rvalid_done", miso.rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mosi = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'hFFFF_FFFF;

      //                 wr  id     addr      len  n  data           strb    dly bst rpat          exp
      vecs[0] = '{1'b1, 4'h3, 16'h1004, 2'd3, 4, 40'h0044332211, 5'b01111, 2, 3, 8'hFF,       32'h44332211};
      vecs[1] = '{1'b0, 4'h2, 16'h2000, 2'd3, 0, 40'h00DEADBEEF, 5'b00000, 5, 0, 8'b10011001, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 4'h5, 16'h0010, 2'd1, 2, 40'h000000BBAA, 5'b00011, 1, 0, 8'hFF,       32'h0000BBAA};
      vecs[3] = '{1'b1, 4'h1, 16'h00F0, 2'd3, 4, 40'h0044332211, 5'b01010, 0, 0, 8'hFF,       32'h44002200};
      vecs[4] = '{1'b0, 4'h7, 16'h3FFE, 2'd0, 0, 40'h0012345678, 5'b00000, 0, 0, 8'hFF,       32'h00000078};
      vecs[5] = '{1'b0, 4'hF, 16'hFFFF, 2'd1, 0, 40'h00A5A55A5A, 5'b00000, 2, 0, 8'b01010101, 32'h00005A5A};
      vecs[6] = '{1'b1, 4'h0, 16'h0000, 2'd0, 1, 40'h00000000C3, 5'b00001, 1, 0, 8'hFF,       32'h000000C3};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_awready", miso.awready, 0);
      chk("rst_arready", miso.arready, 0);
      chk("rst_wready", miso.wready, 0);
      chk("rst_bvalid", miso.bvalid, 0);
      chk("rst_rvalid", miso.rvalid, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Contention from reset: write first, then read
      mosi.awvalid = 1'b1; mosi.awid = 4'h4; mosi.awaddr = 16'h0100; mosi.awlen = 8'd0;
      mosi.arvalid = 1'b1; mosi.arid = 4'h6; mosi.araddr = 16'h0200; mosi.arlen = 8'd0;
      #1 chk("rr1_awready", miso.awready, 1);
      chk("rr1_arready", miso.arready, 0);
      step();
      mosi.awvalid = 1'b0;
      mosi.wvalid = 1'b1; mosi.wdata = 8'h5A; mosi.wstrb = 1'b1; mosi.wlast = 1'b1;
      #1 chk("rr1_ar_blocked", miso.arready, 0);
      step();
      mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
      #1 chk("rr1_req_valid", mem_req_valid, 1);
      chk("rr1_wdata", mem_wdata, 32'h0000005A);
      chk("rr1_ar_blocked2", miso.arready, 0);
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;   // same-cycle completion
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      #1 chk("same_cycle_bvalid", miso.bvalid, 1);
      chk("same_cycle_req_off", mem_req_valid, 0);
      mosi.bready = 1'b1;
      step();
      mosi.bready = 1'b0;
      mosi.awvalid = 1'b1;                            // second contention
      #1 chk("rr2_arready", miso.arready, 1);
      chk("rr2_awready", miso.awready, 0);
      step();
      mosi.arvalid = 1'b0;
      #1 chk("rr2_rd_req", mem_req_valid, 1);
      chk("rr2_rd_wr", mem_wr, 0);
      chk("rr2_rd_addr", mem_addr, 16'h0200);
      chk("rr2_aw_blocked", miso.awready, 0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'h000000E7;
      step();
      mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      #1 chk("rr2_rvalid", miso.rvalid, 1);
      chk("rr2_rdata", miso.rdata, 8'hE7);
      chk("rr2_rid", miso.rid, 4'h6);
      chk("rr2_rlast", miso.rlast, 1);
      mosi.rready = 1'b1;
      step();
      mosi.rready = 1'b0;
      #1 chk("rr2_aw_after", miso.awready, 1);
      mosi.awvalid = 1'b0;
      step();

      // Table-driven transactions
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].nbeats, vecs[i].data,
                     vecs[i].strb, vecs[i].delay, vecs[i].bstall, vecs[i].exp_word,
                     AXI_RESP_OKAY, 1'b1);
         else
            do_read(vecs[i].id, vecs[i].addr, vecs[i].len, 3'd0, vecs[i].data[31:0],
                    vecs[i].delay, vecs[i].rpat, vecs[i].exp_word, AXI_RESP_OKAY, 1'b1);
         step();
      end

      // Reset in the middle of a write burst
      mosi.awvalid = 1'b1; mosi.awid = 4'h9; mosi.awaddr = 16'h4444; mosi.awlen = 8'd3;
      step();
      mosi.awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mosi.wvalid = 1'b1; mosi.wdata = 8'(b + 1); mosi.wstrb = 1'b1; mosi.wlast = 1'b0;
         step();
      end
      mosi.wvalid = 1'b0;
      rst = 1'b1;
      #1 chk("mid_rst_wready", miso.wready, 0);
      chk("mid_rst_req", mem_req_valid, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_bvalid", miso.bvalid, 0);
      step();
      rst = 1'b0;
      step();
      do_write(4'hA, 16'h5555, 2'd1, 2, 40'h0000006655, 5'b00011, 1, 0, 32'h00006655,
               AXI_RESP_OKAY, 1'b1);
      step();

`ifdef AXI_SR_RESP_CHECK_EN
      // Early WLAST: dropped, SLVERR
      do_write(4'hC, 16'h0C00, 2'd3, 2, 40'h000000BBAA, 5'b00011, 0, 0, 32'h0,
               AXI_RESP_SLVERR, 1'b0);
      step();
      // Fifth beat on a 4-beat burst: dropped, SLVERR
      do_write(4'hD, 16'h0D00, 2'd3, 5, 40'h5544332211, 5'b11111, 0, 0, 32'h0,
               AXI_RESP_SLVERR, 1'b0);
      step();
      // Unsupported ARSIZE: zero data, SLVERR, no memory access
      do_read(4'h3, 16'h0300, 2'd1, 3'd1, 32'h0, 0, 8'hFF, 32'h0, AXI_RESP_SLVERR, 1'b0);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
